// File: rtl/fdd_rdat_gen_if.sv
// rtl/fdd_rdat_gen_if.sv - raw track byte stream between the image buffer and fdd_rdat_gen
interface fdd_rdat_gen_if;
   logic [7:0] byte_data;
   logic       byte_valid;
   logic       byte_ready;

   modport master (output byte_data, output byte_valid, input byte_ready);
   modport slave  (input byte_data, input byte_valid, output byte_ready);
endinterface

// File: rtl/fdd_rdat_gen.sv
// rtl/fdd_rdat_gen.sv - emulated drive read data: serialises a raw MFM track into rdat_n/index_n
module fdd_rdat_gen #(
   parameter int CELL_CLKS   = 56,
   parameter int PULSE_CLKS  = 4,
   parameter int INDEX_BYTES = 250
) (
   input  logic          fclk,
   input  logic          rst_n,
   input  logic          enable,
   input  logic [13:0]   track_len,
   fdd_rdat_gen_if.slave src,
   input  logic          underrun_clr,
   output logic          rdat_n,
   output logic          index_n,
   output logic          underrun,
   output logic [13:0]   byte_pos
);
   localparam logic [7:0]  CELL_LAST = 8'(CELL_CLKS - 1);
   localparam logic [7:0]  PULSE_LEN = 8'(PULSE_CLKS);
   localparam logic [13:0] INDEX_LEN = 14'(INDEX_BYTES);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state, state_nx;
   logic [13:0] len_q;
   logic [2:0]  bit_idx;
   logic [7:0]  cell_cnt;
   logic [7:0]  shreg;
   logic        cell_end;
   logic        start;
   logic        load_pt;
   logic        do_load;
   logic [7:0]  load_byte;

   assign cell_end  = (cell_cnt == CELL_LAST);
   assign load_byte = src.byte_valid ? src.byte_data : 8'h00;

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (enable && (track_len != '0)) state_nx = RUN;
         RUN:     if (!enable) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // byte_ready is a combinational pop strobe; gating with rst_n keeps it low during reset
   always_comb begin
      start   = 1'b0;
      load_pt = 1'b0;
      case (state)
         IDLE:    start   = enable && (track_len != '0);
         RUN:     load_pt = enable && cell_end && (bit_idx == 3'd7);
         default: ;
      endcase
      do_load        = rst_n && (start || load_pt);
      src.byte_ready = do_load && src.byte_valid;
   end

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         len_q    <= '0;
         byte_pos <= '0;
         bit_idx  <= '0;
         cell_cnt <= '0;
         shreg    <= '0;
      end else if ((state == RUN) && !enable) begin
         byte_pos <= '0;
         bit_idx  <= '0;
         cell_cnt <= '0;
         shreg    <= '0;
      end else if (start) begin
         len_q    <= track_len;
         byte_pos <= '0;
         bit_idx  <= '0;
         cell_cnt <= '0;
         shreg    <= load_byte;
      end else if (state == RUN) begin
         if (cell_end) begin
            cell_cnt <= '0;
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
               byte_pos <= (byte_pos == len_q - 14'd1) ? 14'd0 : byte_pos + 14'd1;
               shreg    <= load_byte;
            end else begin
               shreg <= {shreg[6:0], 1'b0};
            end
         end else begin
            cell_cnt <= cell_cnt + 8'd1;
         end
      end
   end

   // a new underrun outranks a simultaneous clear so no lost byte goes unreported
   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n)                             underrun <= 1'b0;
      else if (do_load && !src.byte_valid)    underrun <= 1'b1;
      else if (underrun_clr)                  underrun <= 1'b0;
   end

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         rdat_n  <= 1'b1;
         index_n <= 1'b1;
      end else begin
         rdat_n  <= !((state == RUN) && shreg[7] && (cell_cnt < PULSE_LEN));
         index_n <= !((state == RUN) && (byte_pos < INDEX_LEN));
      end
   end
endmodule

// File: tb/tb_fdd_rdat_gen.sv
// tb/tb_fdd_rdat_gen.sv - self-checking bench for fdd_rdat_gen
module tb_fdd_rdat_gen;
   localparam int CELL  = 56;
   localparam int PULSE = 4;
   localparam int IDXB  = 10;
   localparam int BYTEC = 8 * CELL;

   logic        fclk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [13:0] track_len;
   logic        underrun_clr;
   logic        rdat_n;
   logic        index_n;
   logic        underrun;
   logic [13:0] byte_pos;

   fdd_rdat_gen_if bif();

   fdd_rdat_gen #(.CELL_CLKS(CELL), .PULSE_CLKS(PULSE), .INDEX_BYTES(IDXB)) dut (
      .fclk         (fclk),
      .rst_n        (rst_n),
      .enable       (enable),
      .track_len    (track_len),
      .src          (bif.slave),
      .underrun_clr (underrun_clr),
      .rdat_n       (rdat_n),
      .index_n      (index_n),
      .underrun     (underrun),
      .byte_pos     (byte_pos)
   );

   always #5 fclk = ~fclk;

   int cyc = 0;
   always @(posedge fclk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // scoreboard: each popped byte pushes the cycle at which every '1' cell must first show low
   int   exp_q[$];
   int   pop_cnt = 0, pulse_cnt = 0, low_len = 0;
   int   last_pop = 0, wrap_cnt = 0, max_pos = 0;
   int   last_fall = 0, prev_fall = 0, last_rise = 0;
   logic last_pop_valid = 1'b0, skip_width = 1'b0, mon_en = 1'b0;
   logic prev_rd = 1'b1, prev_idx = 1'b1;
   logic [13:0] prev_pos = '0;

   always @(negedge fclk) begin
      if (mon_en) begin
         if (bif.byte_ready) begin
            pop_cnt++;
            if (last_pop_valid) check("pop_spacing", 32'((cyc - last_pop) % BYTEC), 32'd0);
            last_pop       = cyc;
            last_pop_valid = 1'b1;
            for (int b = 0; b < 8; b++)
               if (bif.byte_data[7-b]) exp_q.push_back(cyc + 2 + CELL * b);
         end
         if (!rdat_n && prev_rd) begin
            pulse_cnt++;
            if (exp_q.size() == 0) check("pulse_unexpected", 32'(cyc), 32'd0);
            else                   check("pulse_time", 32'(cyc), 32'(exp_q.pop_front()));
         end
         if (!rdat_n) low_len++;
         if (rdat_n && !prev_rd) begin
            if (!skip_width) check("pulse_width", 32'(low_len), 32'(PULSE));
            low_len = 0;
         end
         if (!index_n && prev_idx) begin prev_fall = last_fall; last_fall = cyc; end
         if (index_n && !prev_idx) last_rise = cyc;
         if (byte_pos == 14'd0 && prev_pos == 14'(11)) wrap_cnt++;
         if (int'(byte_pos) > max_pos) max_pos = int'(byte_pos);
      end
      prev_rd  = rdat_n;
      prev_idx = index_n;
      prev_pos = byte_pos;
   end

   task automatic wait_cyc(input int t);
      while (cyc < t) begin @(posedge fclk); #1; end
   endtask

   task automatic sample();
      @(negedge fclk); #1;
   endtask

   task automatic start_run(output int n);
      @(posedge fclk); #1;
      last_pop_valid = 1'b0;
      enable = 1'b1;
      n = cyc;
   endtask

   typedef struct {
      logic [7:0]  data;
      logic [13:0] len;
      int          npulse;
      int          pos_mid;
   } vec_t;

   vec_t vecs[6];
   int   n, p0, q0;

   initial begin
      vecs[0] = '{8'hA5, 14'd4,  4, 1};
      vecs[1] = '{8'hFF, 14'd1,  8, 0};
      vecs[2] = '{8'h01, 14'd2,  1, 1};
      vecs[3] = '{8'h80, 14'd12, 1, 1};
      vecs[4] = '{8'h3C, 14'd10, 4, 1};
      vecs[5] = '{8'h00, 14'd4,  0, 1};

      rst_n = 1'b0; enable = 1'b1; track_len = 14'd4; underrun_clr = 1'b0;
      bif.byte_data = 8'hA5; bif.byte_valid = 1'b1;
      repeat (3) @(posedge fclk);
      #1;
      check("rst_rdat_n",     32'(rdat_n), 32'd1);
      check("rst_index_n",    32'(index_n), 32'd1);
      check("rst_byte_ready", 32'(bif.byte_ready), 32'd0);
      check("rst_underrun",   32'(underrun), 32'd0);
      check("rst_byte_pos",   32'(byte_pos), 32'd0);
      enable = 1'b0;
      @(posedge fclk); #1;
      rst_n = 1'b1;
      mon_en = 1'b1;

      // zero track length never leaves IDLE
      q0 = pop_cnt;
      track_len = 14'd0; enable = 1'b1;
      wait_cyc(cyc + 100); sample();
      check("len0_pops",     32'(pop_cnt - q0), 32'd0);
      check("len0_rdat_n",   32'(rdat_n), 32'd1);
      check("len0_index_n",  32'(index_n), 32'd1);
      check("len0_byte_pos", 32'(byte_pos), 32'd0);
      enable = 1'b0;
      wait_cyc(cyc + 5);

      foreach (vecs[i]) begin
         bif.byte_data = vecs[i].data; bif.byte_valid = 1'b1; track_len = vecs[i].len;
         p0 = pulse_cnt; q0 = pop_cnt;
         start_run(n);
         sample();
         check("vec_pop_on_enable", 32'(pop_cnt - q0), 32'd1);
         wait_cyc(n + 600); sample();
         check("vec_byte_pos", 32'(byte_pos), 32'(vecs[i].pos_mid));
         check("vec_index_low", 32'(index_n), 32'd0);
         wait_cyc(n + 890);
         enable = 1'b0;
         wait_cyc(n + 895); sample();
         check("vec_pulses",   32'(pulse_cnt - p0), 32'(2 * vecs[i].npulse));
         check("vec_pops",     32'(pop_cnt - q0), 32'd2);
         check("vec_idle_rd",  32'(rdat_n), 32'd1);
         check("vec_idle_idx", 32'(index_n), 32'd1);
         check("vec_sb_empty", 32'(exp_q.size()), 32'd0);
      end

      // index timing over two revolutions; mid-run track_len change is ignored
      bif.byte_data = 8'h00; track_len = 14'd12;
      p0 = pulse_cnt; wrap_cnt = 0; max_pos = 0;
      start_run(n);
      wait_cyc(n + 5);
      track_len = 14'd3;
      wait_cyc(n + 10056); sample();
      check("idx_first_fall", 32'(prev_fall), 32'(n + 2));
      check("idx_period",     32'(last_fall - prev_fall), 32'(12 * BYTEC));
      check("idx_low_width",  32'(last_rise - last_fall), 32'(IDXB * BYTEC));
      check("idx_wraps",      32'(wrap_cnt), 32'd1);
      check("idx_max_pos",    32'(max_pos), 32'd11);
      check("idx_no_pulses",  32'(pulse_cnt - p0), 32'd0);
      enable = 1'b0;
      wait_cyc(cyc + 5);

      // underrun at the second load point, then set-vs-clear on the third
      underrun_clr = 1'b1;
      @(posedge fclk); #1;
      underrun_clr = 1'b0;
      sample();
      check("ur_cleared", 32'(underrun), 32'd0);
      bif.byte_data = 8'hFF; bif.byte_valid = 1'b1; track_len = 14'd4;
      p0 = pulse_cnt; q0 = pop_cnt;
      start_run(n);
      wait_cyc(n + 1);
      bif.byte_valid = 1'b0;
      wait_cyc(n + 600); sample();
      check("ur_set",  32'(underrun), 32'd1);
      check("ur_pops", 32'(pop_cnt - q0), 32'd1);
      wait_cyc(n + 896);
      underrun_clr = 1'b1;
      wait_cyc(n + 897);
      underrun_clr = 1'b0;
      sample();
      check("ur_set_wins", 32'(underrun), 32'd1);
      wait_cyc(n + 1000);
      underrun_clr = 1'b1;
      wait_cyc(n + 1001);
      underrun_clr = 1'b0;
      sample();
      check("ur_clr",     32'(underrun), 32'd0);
      check("ur_pulses",  32'(pulse_cnt - p0), 32'd8);
      check("ur_pops2",   32'(pop_cnt - q0), 32'd1);
      enable = 1'b0;
      wait_cyc(cyc + 5);

      // disable two clocks into the first pulse, then restart from byte 0
      bif.byte_valid = 1'b1;
      skip_width = 1'b1;
      start_run(n);
      wait_cyc(n + 3);
      enable = 1'b0;
      wait_cyc(n + 5); sample();
      check("dis_rdat_n",   32'(rdat_n), 32'd1);
      check("dis_index_n",  32'(index_n), 32'd1);
      check("dis_byte_pos", 32'(byte_pos), 32'd0);
      wait_cyc(n + 8);
      exp_q.delete();
      skip_width = 1'b0;
      p0 = pulse_cnt; q0 = pop_cnt;
      start_run(n);
      sample();
      check("re_pop", 32'(pop_cnt - q0), 32'd1);
      wait_cyc(n + 2); sample();
      check("re_byte_pos", 32'(byte_pos), 32'd0);
      check("re_index_n",  32'(index_n), 32'd0);
      wait_cyc(n + 420);
      enable = 1'b0;
      wait_cyc(n + 425); sample();
      check("re_pulses",   32'(pulse_cnt - p0), 32'd8);
      check("re_sb_empty", 32'(exp_q.size()), 32'd0);

      // asynchronous reset in the middle of a pulse
      bif.byte_valid = 1'b0;
      q0 = pop_cnt;
      start_run(n);
      wait_cyc(n + 5);
      bif.byte_valid = 1'b1;
      wait_cyc(n + 450); sample();
      check("ar_pop",      32'(pop_cnt - q0), 32'd1);
      check("ar_underrun", 32'(underrun), 32'd1);
      check("ar_rdat_low", 32'(rdat_n), 32'd0);
      skip_width = 1'b1;
      wait_cyc(n + 451);
      #2 rst_n = 1'b0;
      #1;
      check("ar_rdat_n",     32'(rdat_n), 32'd1);
      check("ar_index_n",    32'(index_n), 32'd1);
      check("ar_byte_ready", 32'(bif.byte_ready), 32'd0);
      check("ar_underrun0",  32'(underrun), 32'd0);
      check("ar_byte_pos",   32'(byte_pos), 32'd0);
      enable = 1'b0;
      exp_q.delete();
      wait_cyc(cyc + 3);
      rst_n = 1'b1;
      wait_cyc(cyc + 2);
      skip_width = 1'b0;
      q0 = pop_cnt;
      wait_cyc(cyc + 50); sample();
      check("post_rst_pops",   32'(pop_cnt - q0), 32'd0);
      check("post_rst_rdat_n", 32'(rdat_n), 32'd1);
      check("post_rst_idx",    32'(index_n), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fdd_rdat_gen.md
FDD_RDAT_GEN -- requirements
Module: fdd_rdat_gen

Purpose: emulated-drive read-data source feeding the FDC read path (rdat_n into the RCLK/RAWR recovery stage). It serialises a raw MFM track image into active-low flux pulses plus an index pulse.

Interface
REQ-001 Parameter CELL_CLKS, default 56: fclk cycles per MFM bit cell (2 us at 28 MHz).
REQ-002 Parameter PULSE_CLKS, default 4: rdat_n low width in fclk cycles.
REQ-003 Parameter INDEX_BYTES, default 250: track bytes at the start of the track during which index_n is low.
REQ-004 fclk  in  1  28 MHz clock; all state is on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 enable  in  1  drive selected, motor on and image present; 0 stops streaming.
REQ-007 track_len  in  14  raw track length in bytes; sampled only when leaving IDLE.
REQ-008 byte_data  in  8  next raw cell byte, MSB first.
REQ-009 byte_valid  in  1  byte_data holds a valid byte.
REQ-010 byte_ready  out  1  one-cycle pop strobe; byte_data is consumed on that cycle.
REQ-011 underrun_clr  in  1  clears underrun.
REQ-012 rdat_n  out  1  flux pulse output, active-low.
REQ-013 index_n  out  1  index pulse output, active-low.
REQ-014 underrun  out  1  sticky flag: a byte was needed while byte_valid was 0.
REQ-015 byte_pos  out  14  index of the byte currently being shifted.

Function
REQ-016 The block SHALL have two states: IDLE and RUN.
REQ-017 IDLE to RUN SHALL occur on a clock with enable=1 and track_len!=0.
- On that clock, track_len is latched, byte_pos=0, bit_idx=0, cell_cnt=0.
- The first byte is loaded per REQ-020.
REQ-018 In RUN:
- cell_cnt counts 0..CELL_CLKS-1, then wraps.
- On each wrap, bit_idx advances 0..7, then wraps.
REQ-019 Byte-load point: the clock where cell_cnt=CELL_CLKS-1 and bit_idx=7.
- byte_pos advances; it wraps to 0 when byte_pos=latched_len-1.
- The next byte is loaded per REQ-020.
REQ-020 Byte load:
- If byte_valid=1: byte_ready=1 for exactly that cycle, and byte_data goes into the shift register.
- If byte_valid=0: byte_ready=0, shift register loads 8'h00, underrun is set.
REQ-021 byte_ready SHALL never be asserted outside a byte-load clock.
REQ-022 rdat_n is registered.
- It is 0 on the clock after any clock where state=RUN, the current cell bit=1 and cell_cnt<PULSE_CLKS; otherwise 1.
- Each '1' cell therefore gives exactly PULSE_CLKS low cycles, starting 1 clock after the cell begins.
REQ-023 index_n is registered: 0 while state=RUN and byte_pos<INDEX_BYTES, else 1.
- If latched_len<=INDEX_BYTES, index_n stays low for the whole revolution.
REQ-024 enable=0 in RUN SHALL return to IDLE on the next clock, including mid-cell or mid-pulse.
- rdat_n and index_n go to 1 on the clock after that.
- byte_pos returns to 0 and byte_ready is not asserted.
REQ-025 track_len changes during RUN SHALL be ignored until the next IDLE to RUN.
REQ-026 underrun set and underrun_clr on the same clock: set wins.
REQ-027 CELL_CLKS SHALL be >PULSE_CLKS and <=255.

Reset
REQ-028 While rst_n=0, all of the following SHALL hold asynchronously: state=IDLE, rdat_n=1, index_n=1, byte_ready=0, underrun=0, byte_pos=0, cell_cnt=0, bit_idx=0, shift register=0.
REQ-029 After reset release, streaming SHALL start only via REQ-017.

Verification
REQ-030 Byte 8'hA5 valid, track_len=4, enable rises:
- byte_ready pulses on the enable clock.
- rdat_n goes low for 4 clocks at cells 0, 2, 5, 7.
- Each falling edge is 56 clocks × cell index after the first one.
REQ-031 Continuous valid 8'h00, track_len=300:
- no rdat_n pulses.
- index_n low for exactly 250×448 clocks per 300×448-clock revolution.
- byte_pos wraps 299 to 0.
REQ-032 byte_valid=0 at the second load point:
- byte_ready stays 0, no pulses for that byte, underrun=1.
- underrun_clr on the same clock as a further underrun leaves underrun=1.
REQ-033 enable drops 2 clocks into an rdat_n pulse:
- rdat_n and index_n are 1 within 2 clocks.
- Re-enable restarts at byte_pos=0 with a new pop.
REQ-034 rst_n asserted mid-RUN: all outputs take their reset values immediately, without waiting for a clock edge.
REQ-035 track_len=0 with enable=1: the block stays IDLE, with no byte_ready and rdat_n=1.
